// File: rtl/reg_writeback_pkg.sv
// Shared constants and FSM encoding for the write-back register file.
package reg_writeback_pkg;

  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned REG_COUNT   = 8;
  localparam int unsigned IDX_WIDTH   = 3;
  localparam int unsigned COUNT_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HI   = 1'b1
  } state_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Write-back request channel from the execute stage (valid/ready handshake).
interface reg_writeback_if
  import reg_writeback_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
);

  logic                 wrValid;
  logic                 wrReady;
  logic [IDX_WIDTH-1:0] wrSelect;
  logic                 wrRSelect;
  logic                 wrDual;
  logic [WIDTH-1:0]     wrData;
  logic [WIDTH-1:0]     wrDataHi;

  modport master (
    output wrValid, wrSelect, wrRSelect, wrDual, wrData, wrDataHi,
    input  wrReady
  );

  modport slave (
    input  wrValid, wrSelect, wrRSelect, wrDual, wrData, wrDataHi,
    output wrReady
  );

endinterface

// File: rtl/reg_writeback_reg_cell.sv
// Single register with asynchronous active-low reset and write enable.
module reg_cell #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled, clear on reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Register file write-back: owns GPRs reg0..reg7 and regR, serialises dual writes.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int unsigned WIDTH    = DATA_WIDTH,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                   clock,
  input  logic                   resetn,
  reg_writeback_if.slave         wr,
  output logic [WIDTH-1:0]       reg0,
  output logic [WIDTH-1:0]       reg1,
  output logic [WIDTH-1:0]       reg2,
  output logic [WIDTH-1:0]       reg3,
  output logic [WIDTH-1:0]       reg4,
  output logic [WIDTH-1:0]       reg5,
  output logic [WIDTH-1:0]       reg6,
  output logic [WIDTH-1:0]       reg7,
  output logic [WIDTH-1:0]       regR,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] commitCount
);

  state_t           state;
  logic [WIDTH-1:0] hold_hi;
  logic             accept;
  logic             gpr_write;
  logic             r_en;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] gpr [REG_COUNT];

  // Ready drops combinationally with resetn so nothing is accepted during reset.
  assign wr.wrReady = (state == IDLE) && resetn;
  assign busy       = (state == HI);
  assign accept     = wr.wrValid && wr.wrReady;
  assign gpr_write  = accept && (wr.wrDual || !wr.wrRSelect);

  // regR takes the held high word in HI, otherwise a single regR write.
  assign r_en = (state == HI) || (accept && !wr.wrDual && wr.wrRSelect);
  assign r_d  = (state == HI) ? hold_hi : wr.wrData;

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_gpr
    if (i == 0 && ZERO_REG) begin : g_zero
      assign gpr[i] = '0;
    end else begin : g_cell
      logic en;
      assign en = gpr_write && (wr.wrSelect == IDX_WIDTH'(i));
      reg_cell #(.WIDTH(WIDTH)) u_cell (
        .clock  (clock),
        .resetn (resetn),
        .en     (en),
        .d      (wr.wrData),
        .q      (gpr[i])
      );
    end
  end

  reg_cell #(.WIDTH(WIDTH)) u_reg_r (
    .clock  (clock),
    .resetn (resetn),
    .en     (r_en),
    .d      (r_d),
    .q      (regR)
  );

  assign reg0 = gpr[0];
  assign reg1 = gpr[1];
  assign reg2 = gpr[2];
  assign reg3 = gpr[3];
  assign reg4 = gpr[4];
  assign reg5 = gpr[5];
  assign reg6 = gpr[6];
  assign reg7 = gpr[7];

  // Dual-write sequencing: capture the high word on accept, retire it next cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      hold_hi <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && wr.wrDual) begin
            hold_hi <= wr.wrDataHi;
            state   <= HI;
          end
        end
        HI:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Count accepted requests; a dual write counts once.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      commitCount <= '0;
    end else if (accept) begin
      commitCount <= commitCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: two instances (ZERO_REG=1 and 0) driven in lockstep.
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  reg_writeback_if #(.WIDTH(16)) wa ();
  reg_writeback_if #(.WIDTH(16)) wb ();

  logic [15:0] oa [9];
  logic [15:0] ob [9];
  logic        busy_a, busy_b;
  logic [15:0] cnt_a, cnt_b;

  reg_writeback #(.WIDTH(16), .ZERO_REG(1'b1)) dut_a (
    .clock(clock), .resetn(resetn), .wr(wa),
    .reg0(oa[0]), .reg1(oa[1]), .reg2(oa[2]), .reg3(oa[3]),
    .reg4(oa[4]), .reg5(oa[5]), .reg6(oa[6]), .reg7(oa[7]),
    .regR(oa[8]), .busy(busy_a), .commitCount(cnt_a)
  );

  reg_writeback #(.WIDTH(16), .ZERO_REG(1'b0)) dut_b (
    .clock(clock), .resetn(resetn), .wr(wb),
    .reg0(ob[0]), .reg1(ob[1]), .reg2(ob[2]), .reg3(ob[3]),
    .reg4(ob[4]), .reg5(ob[5]), .reg6(ob[6]), .reg7(ob[7]),
    .regR(ob[8]), .busy(busy_b), .commitCount(cnt_b)
  );

  // Reference model: architectural register contents plus a pending high word.
  logic [15:0] mg [2][8];
  logic [15:0] mr;
  logic [15:0] m_hold;
  logic [15:0] m_cnt;
  bit          m_busy;
  bit          m_inrst;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) mg[k][i] = '0;
    mr     = '0;
    m_hold = '0;
    m_cnt  = '0;
    m_busy = 1'b0;
  endtask

  task automatic model_gpr(input logic [2:0] sel, input logic [15:0] d);
    mg[1][sel] = d;
    if (sel != 3'd0) mg[0][sel] = d;
  endtask

  task automatic model_edge(input bit v, input logic [2:0] sel, input bit rsel,
                            input bit dual, input logic [15:0] d, input logic [15:0] dh);
    if (m_inrst) return;
    if (m_busy) begin
      mr     = m_hold;
      m_busy = 1'b0;
    end else if (v) begin
      m_cnt = m_cnt + 16'd1;
      if (dual) begin
        model_gpr(sel, d);
        m_hold = dh;
        m_busy = 1'b1;
      end else if (rsel) begin
        mr = d;
      end else begin
        model_gpr(sel, d);
      end
    end
  endtask

  task automatic check_all();
    logic exp_ready;
    exp_ready = !m_busy && !m_inrst;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a.reg%0d", i), oa[i], mg[0][i]);
      chk($sformatf("b.reg%0d", i), ob[i], mg[1][i]);
    end
    chk("a.regR", oa[8], mr);
    chk("b.regR", ob[8], mr);
    chk("a.count", cnt_a, m_cnt);
    chk("b.count", cnt_b, m_cnt);
    chk("a.busy", busy_a, m_busy);
    chk("b.busy", busy_b, m_busy);
    chk("a.ready", wa.wrReady, exp_ready);
    chk("b.ready", wb.wrReady, exp_ready);
  endtask

  task automatic drive(input bit v, input logic [2:0] sel, input bit rsel,
                       input bit dual, input logic [15:0] d, input logic [15:0] dh);
    wa.wrValid = v;
    wb.wrValid = v;
    if (v) begin
      wa.wrSelect = sel;  wa.wrRSelect = rsel; wa.wrDual = dual;
      wa.wrData   = d;    wa.wrDataHi  = dh;
      wb.wrSelect = sel;  wb.wrRSelect = rsel; wb.wrDual = dual;
      wb.wrData   = d;    wb.wrDataHi  = dh;
    end else begin
      wa.wrSelect = 'x;   wa.wrRSelect = 1'bx; wa.wrDual = 1'bx;
      wa.wrData   = 'x;   wa.wrDataHi  = 'x;
      wb.wrSelect = 'x;   wb.wrRSelect = 1'bx; wb.wrDual = 1'bx;
      wb.wrData   = 'x;   wb.wrDataHi  = 'x;
    end
  endtask

  // One cycle: check current outputs, present a request, advance model and clock.
  task automatic step(input bit v, input logic [2:0] sel, input bit rsel,
                      input bit dual, input logic [15:0] d, input logic [15:0] dh);
    @(negedge clock);
    check_all();
    drive(v, sel, rsel, dual, d, dh);
    model_edge(v, sel, rsel, dual, d, dh);
    @(posedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn  = 1'b0;
    m_inrst = 1'b1;
    model_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #1 check_all();
    repeat (2) @(negedge clock);
    resetn  = 1'b1;
    m_inrst = 1'b0;
    #1 chk("rst_release_ready", wa.wrReady, 1'b1);
  endtask

  initial begin
    m_inrst = 1'b1;
    model_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Reset held for two cycles, then released.
    @(negedge clock);
    check_all();
    @(negedge clock);
    chk("rst_ready_low", wa.wrReady, 1'b0);
    resetn  = 1'b1;
    m_inrst = 1'b0;
    #1 chk("rst_ready_high", wa.wrReady, 1'b1);

    // Back-to-back singles.
    step(1'b1, 3'd2, 1'b0, 1'b0, 16'd3, 16'h0);
    step(1'b1, 3'd3, 1'b0, 1'b0, 16'd8, 16'h0);
    step(1'b1, 3'd0, 1'b1, 1'b0, 16'd30, 16'h0);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("single_reg2", oa[2], 16'd3);
    chk("single_reg3", oa[3], 16'd8);
    chk("single_regR", oa[8], 16'd30);
    chk("single_count", cnt_a, 16'd3);

    // Write to index 0 on both zero-register variants.
    step(1'b1, 3'd0, 1'b0, 1'b0, 16'h00FF, 16'h0);
    #1;
    chk("zr1_reg0", oa[0], 16'h0000);
    chk("zr0_reg0", ob[0], 16'h00FF);
    chk("zr_count", cnt_a, 16'd4);

    // Dual write, then a request held across the HI cycle.
    step(1'b1, 3'd6, 1'b0, 1'b1, 16'h1234, 16'hABCD);
    #1;
    chk("dual_e1_reg6", oa[6], 16'h1234);
    chk("dual_e1_busy", busy_a, 1'b1);
    chk("dual_e1_ready", wa.wrReady, 1'b0);
    chk("dual_e1_regR_old", oa[8], 16'd30);
    step(1'b1, 3'd5, 1'b0, 1'b0, 16'h5555, 16'h0);
    #1;
    chk("dual_e2_regR", oa[8], 16'hABCD);
    chk("dual_e2_busy", busy_a, 1'b0);
    chk("dual_held_not_yet", oa[5], 16'h0000);
    step(1'b1, 3'd5, 1'b0, 1'b0, 16'h5555, 16'h0);
    #1;
    chk("dual_held_taken", oa[5], 16'h5555);
    chk("dual_count", cnt_a, 16'd6);

    // Dual with index 0 still reaches regR.
    step(1'b1, 3'd0, 1'b0, 1'b1, 16'h0101, 16'h7E7E);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #1 chk("dual_zero_regR", oa[8], 16'h7E7E);

    // Asynchronous reset while the high word is pending.
    step(1'b1, 3'd7, 1'b0, 1'b1, 16'h7777, 16'h9999);
    #2;
    chk("mid_busy_before", busy_a, 1'b1);
    resetn  = 1'b0;
    m_inrst = 1'b1;
    model_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #1;
    check_all();
    chk("mid_regR_zero", oa[8], 16'h0000);
    chk("mid_reg7_zero", oa[7], 16'h0000);
    repeat (2) @(negedge clock);
    resetn  = 1'b1;
    m_inrst = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #1 chk("mid_regR_after", oa[8], 16'h0000);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom));
    end
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Counter wrap: 65536 accepts return the count to zero.
    do_reset();
    for (int n = 0; n < 65536; n++) begin
      logic [2:0]  s;
      logic [15:0] d;
      s = 3'($urandom_range(0, 7));
      d = 16'($urandom);
      @(negedge clock);
      drive(1'b1, s, 1'b0, 1'b0, d, 16'h0);
      model_edge(1'b1, s, 1'b0, 1'b0, d, 16'h0);
      @(posedge clock);
    end
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("wrap_zero_a", cnt_a, 16'd0);
    chk("wrap_zero_b", cnt_b, 16'd0);
    step(1'b1, 3'd1, 1'b0, 1'b0, 16'h4242, 16'h0);
    #1;
    chk("wrap_one_a", cnt_a, 16'd1);
    chk("wrap_one_b", cnt_b, 16'd1);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
